// File: rtl/mix_pkg.sv
// Shared types and helpers for the audio mix engine: FSM states, accumulator
// sizing and sample saturation.
package mix_pkg;

  localparam int GAIN_W = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    ACC,
    WR_REQ,
    WR_WAIT,
    AUD,
    NEXT,
    DONE
  } mix_state_t;

  // Wide enough to sum NUM_CH full-scale samples without wrapping.
  function automatic int acc_width(input int samp_w, input int num_ch);
    return samp_w + $clog2(num_ch) + 1;
  endfunction

  // Clamp a signed value into the signed range of a samp_w-bit sample.
  function automatic longint sat_sample(input longint v, input int samp_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (samp_w - 1)) - 1;
    lo = -(longint'(1) <<< (samp_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mix_sat_acc.sv
// One channel-half accumulator: sign-extend, arithmetic shift by gain,
// accumulate, and present the saturated result with a clip flag.
module mix_sat_acc
  import mix_pkg::*;
#(
  parameter int SAMP_W = 16,
  parameter int ACC_W  = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [SAMP_W-1:0] sample,
  input  logic [GAIN_W-1:0] gain,
  output logic [SAMP_W-1:0] sat_out,
  output logic              clipped
);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] shifted;
  longint                  acc_wide;
  longint                  sat_wide;

  always_comb begin
    ext     = {{(ACC_W - SAMP_W){sample[SAMP_W-1]}}, sample};
    shifted = ext >>> gain;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (add_en) begin
      acc_reg <= acc_reg + shifted;
    end
  end

  always_comb begin
    acc_wide = longint'(acc_reg);
    sat_wide = sat_sample(acc_wide, SAMP_W);
    sat_out  = SAMP_W'(sat_wide);
    clipped  = (sat_wide != acc_wide);
  end

endmodule

// File: rtl/mix_engine.sv
// Multi-track audio mixer: reads one stereo word per enabled channel, sums with
// per-channel attenuation and saturation, writes back and streams to the DAC.
// Optional clip counter port enabled by defining MIX_CLIP_COUNT_EN.
module mix_engine
  import mix_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 23,
  parameter int SAMP_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          mix_start,
  input  logic [NUM_CH-1:0][ADDR_W-1:0] mix_src_addr,
  input  logic [ADDR_W-1:0]             mix_dst_addr,
  input  logic [NUM_CH-1:0]             mix_ch_en,
  input  logic [NUM_CH-1:0][GAIN_W-1:0] mix_gain,
  input  logic [LEN_W-1:0]              mix_len,
  output logic                          mix_busy,
  output logic                          mix_done,
  output logic                          mix_read,
  output logic                          mix_write,
  output logic [ADDR_W-1:0]             mix_addr,
  output logic [2*SAMP_W-1:0]           mix_writedata,
  input  logic [2*SAMP_W-1:0]           mix_readdata,
  input  logic                          mix_sdram_finished,
  output logic                          mix_audio_valid,
  output logic [2*SAMP_W-1:0]           mix_audio_data,
  input  logic                          mix_audio_ready
`ifdef MIX_CLIP_COUNT_EN
  ,
  output logic [15:0]                   mix_clip_cnt
`endif
);

  localparam int ACC_W  = acc_width(SAMP_W, NUM_CH);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int DATA_W = 2 * SAMP_W;

  mix_state_t                    state_reg, state_next;
  logic [NUM_CH-1:0][ADDR_W-1:0] src_addr_reg;
  logic [ADDR_W-1:0]             dst_addr_reg;
  logic [NUM_CH-1:0]             ch_en_reg;
  logic [NUM_CH-1:0][GAIN_W-1:0] gain_reg;
  logic [LEN_W-1:0]              len_reg;
  logic [LEN_W-1:0]              word_idx_reg;
  logic [CH_W-1:0]               ch_reg;
  logic [DATA_W-1:0]             rdata_reg;

  logic [CH_W-1:0]   next_ch;
  logic              next_found;
  logic              acc_clr;
  logic              acc_add;
  logic [DATA_W-1:0] sat_word;
  logic [1:0]        clip_flag;
  logic [ADDR_W-1:0] idx_ext;
  logic [LEN_W-1:0]  idx_inc;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_ch = CH_W'(i);
    end
  endfunction

  // Scan downwards so the lowest enabled channel above ch_reg wins.
  always_comb begin
    next_found = 1'b0;
    next_ch    = ch_reg;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en_reg[i] && (CH_W'(i) > ch_reg)) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    idx_ext = ADDR_W'(word_idx_reg);
    idx_inc = word_idx_reg + LEN_W'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mix_start) begin
          if ((mix_ch_en == '0) || (mix_len == '0)) state_next = DONE;
          else                                      state_next = RD_REQ;
        end
      end
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: if (mix_sdram_finished) state_next = ACC;
      ACC:     state_next = next_found ? RD_REQ : WR_REQ;
      WR_REQ:  state_next = WR_WAIT;
      WR_WAIT: if (mix_sdram_finished) state_next = AUD;
      AUD:     if (mix_audio_ready) state_next = NEXT;
      NEXT:    state_next = (idx_inc == len_reg) ? DONE : RD_REQ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg    <= IDLE;
      src_addr_reg <= '0;
      dst_addr_reg <= '0;
      ch_en_reg    <= '0;
      gain_reg     <= '0;
      len_reg      <= '0;
      word_idx_reg <= '0;
      ch_reg       <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (mix_start) begin
            src_addr_reg <= mix_src_addr;
            dst_addr_reg <= mix_dst_addr;
            ch_en_reg    <= mix_ch_en;
            gain_reg     <= mix_gain;
            len_reg      <= mix_len;
            word_idx_reg <= '0;
            ch_reg       <= lowest_ch(mix_ch_en);
          end
        end
        RD_WAIT: if (mix_sdram_finished) rdata_reg <= mix_readdata;
        ACC:     if (next_found) ch_reg <= next_ch;
        NEXT: begin
          word_idx_reg <= idx_inc;
          ch_reg       <= lowest_ch(ch_en_reg);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    acc_clr = ((state_reg == IDLE) && mix_start) || (state_reg == NEXT);
    acc_add = (state_reg == ACC);
  end

  // Half 0 is the right sample (low bits), half 1 the left sample.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      mix_sat_acc #(
        .SAMP_W(SAMP_W),
        .ACC_W (ACC_W)
      ) u_acc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clr    (acc_clr),
        .add_en (acc_add),
        .sample (rdata_reg[gi*SAMP_W +: SAMP_W]),
        .gain   (gain_reg[ch_reg]),
        .sat_out(sat_word[gi*SAMP_W +: SAMP_W]),
        .clipped(clip_flag[gi])
      );
    end
  endgenerate

  // Outputs decode straight from state so reset forces them all to zero at once.
  always_comb begin
    mix_busy        = (state_reg != IDLE) && (state_reg != DONE);
    mix_done        = (state_reg == DONE);
    mix_read        = (state_reg == RD_REQ) || (state_reg == RD_WAIT);
    mix_write       = (state_reg == WR_REQ) || (state_reg == WR_WAIT);
    mix_addr        = '0;
    mix_writedata   = '0;
    mix_audio_valid = (state_reg == AUD);
    mix_audio_data  = '0;
    if (mix_read)        mix_addr = src_addr_reg[ch_reg] + idx_ext;
    if (mix_write) begin
      mix_addr      = dst_addr_reg + idx_ext;
      mix_writedata = sat_word;
    end
    if (mix_audio_valid) mix_audio_data = sat_word;
  end

`ifdef MIX_CLIP_COUNT_EN
  logic [15:0] clip_cnt_reg;

  // Sampled once per word, in the single WR_REQ cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      clip_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && mix_start) begin
      clip_cnt_reg <= '0;
    end else if ((state_reg == WR_REQ) && (|clip_flag) && (clip_cnt_reg != 16'hFFFF)) begin
      clip_cnt_reg <= clip_cnt_reg + 16'd1;
    end
  end

  assign mix_clip_cnt = clip_cnt_reg;
`endif

endmodule

// File: tb/tb_mix_engine.sv
// Directed self-checking bench for mix_engine with a simple SDRAM responder
// and audio sink; prints one line per bus transaction.
module tb_mix_engine;
  import mix_pkg::*;

  localparam int NUM_CH = 8;
  localparam int ADDR_W = 23;
  localparam int SAMP_W = 16;
  localparam int LEN_W  = 16;

  logic                          i_clk;
  logic                          i_rst;
  logic                          mix_start;
  logic [NUM_CH-1:0][ADDR_W-1:0] mix_src_addr;
  logic [ADDR_W-1:0]             mix_dst_addr;
  logic [NUM_CH-1:0]             mix_ch_en;
  logic [NUM_CH-1:0][2:0]        mix_gain;
  logic [LEN_W-1:0]              mix_len;
  logic                          mix_busy;
  logic                          mix_done;
  logic                          mix_read;
  logic                          mix_write;
  logic [ADDR_W-1:0]             mix_addr;
  logic [2*SAMP_W-1:0]           mix_writedata;
  logic [2*SAMP_W-1:0]           mix_readdata;
  logic                          mix_sdram_finished;
  logic                          mix_audio_valid;
  logic [2*SAMP_W-1:0]           mix_audio_data;
  logic                          mix_audio_ready;
`ifdef MIX_CLIP_COUNT_EN
  logic [15:0]                   mix_clip_cnt;
`endif

  mix_engine #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .SAMP_W(SAMP_W), .LEN_W(LEN_W)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .mix_start         (mix_start),
    .mix_src_addr      (mix_src_addr),
    .mix_dst_addr      (mix_dst_addr),
    .mix_ch_en         (mix_ch_en),
    .mix_gain          (mix_gain),
    .mix_len           (mix_len),
    .mix_busy          (mix_busy),
    .mix_done          (mix_done),
    .mix_read          (mix_read),
    .mix_write         (mix_write),
    .mix_addr          (mix_addr),
    .mix_writedata     (mix_writedata),
    .mix_readdata      (mix_readdata),
    .mix_sdram_finished(mix_sdram_finished),
    .mix_audio_valid   (mix_audio_valid),
    .mix_audio_data    (mix_audio_data),
    .mix_audio_ready   (mix_audio_ready)
`ifdef MIX_CLIP_COUNT_EN
    ,
    .mix_clip_cnt      (mix_clip_cnt)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int sd_wait      = 0;
  int req_cnt      = 0;
  int traffic_cnt  = 0;
  int rw_overlap   = 0;

  logic [31:0]       mem [logic [22:0]];
  logic [22:0]       rd_q[$];
  logic [22:0]       wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [31:0]       aud_q[$];
  logic [7:0][22:0]  src;
  logic [7:0][2:0]   gain;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SDRAM responder: finished arrives 1 + sd_wait cycles after the request appears.
  initial begin
    mix_sdram_finished = 1'b0;
    mix_readdata       = '0;
    forever begin
      @(negedge i_clk);
      mix_sdram_finished = 1'b0;
      if (mix_read && mix_write) rw_overlap++;
      if (mix_read || mix_write || mix_audio_valid) traffic_cnt++;
      if (mix_audio_valid && mix_audio_ready) begin
        aud_q.push_back(mix_audio_data);
        $display("[TB] audio data=%h", mix_audio_data);
      end
      if (mix_read || mix_write) begin
        req_cnt++;
        if (req_cnt == 2 + sd_wait) begin
          mix_sdram_finished = 1'b1;
          if (mix_read) begin
            mix_readdata = mem.exists(mix_addr) ? mem[mix_addr] : 32'h0;
            rd_q.push_back(mix_addr);
            $display("[TB] read  addr=%h data=%h", mix_addr, mix_readdata);
          end else begin
            wr_addr_q.push_back(mix_addr);
            wr_data_q.push_back(mix_writedata);
            $display("[TB] write addr=%h data=%h", mix_addr, mix_writedata);
          end
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  task automatic clear_logs();
    rd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    aud_q.delete();
    traffic_cnt = 0;
  endtask

  task automatic run_mix(input logic [7:0] mask, input logic [15:0] len,
                         input logic [22:0] dst, output int cycles);
    bit done_seen;
    clear_logs();
    mix_ch_en    = mask;
    mix_len      = len;
    mix_dst_addr = dst;
    mix_gain     = gain;
    mix_src_addr = src;
    mix_start    = 1'b1;
    @(negedge i_clk);
    mix_start = 1'b0;
    done_seen = 1'b0;
    cycles    = 0;
    for (int k = 1; k <= 3000 && !done_seen; k++) begin
      if (mix_done) begin
        done_seen = 1'b1;
        cycles    = k;
        check("done_busy_low", mix_busy, 1'b0);
      end else begin
        @(negedge i_clk);
      end
    end
    check("done_seen", done_seen, 1'b1);
    @(negedge i_clk);
    check("done_one_cycle", mix_done, 1'b0);
  endtask

  function automatic logic [31:0] q32(input logic [31:0] q[$], input int k);
    return (q.size() > k) ? q[k] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int          cyc;
    logic [31:0] held;
    bit          stable;
    bit          got_valid;

    i_rst = 1'b0;
    mix_start = 1'b0;
    mix_audio_ready = 1'b1;
    mix_ch_en = '0;
    mix_len = '0;
    mix_dst_addr = '0;
    mix_gain = '0;
    for (int i = 0; i < 8; i++) src[i] = 23'h010000 + 23'(i) * 23'h001000;
    mix_src_addr = src;
    gain = '0;
    repeat (3) @(negedge i_clk);

    check("rst_busy", mix_busy, 1'b0);
    check("rst_done", mix_done, 1'b0);
    check("rst_read", mix_read, 1'b0);
    check("rst_write", mix_write, 1'b0);
    check("rst_addr", mix_addr, 23'h0);
    check("rst_valid", mix_audio_valid, 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Two channels, plain sum, zero-wait: 3*2+4 states before DONE.
    mem[src[0]] = 32'h1000_F000;
    mem[src[2]] = 32'h0200_0010;
    run_mix(8'b0000_0101, 16'd1, 23'h200000, cyc);
    check("t1_cycles", cyc, 11);
    check("t1_nreads", rd_q.size(), 2);
    check("t1_rd0", q32(rd_q, 0), src[0]);
    check("t1_rd1", q32(rd_q, 1), src[2]);
    check("t1_nwrites", wr_addr_q.size(), 1);
    check("t1_wr_addr", q32(wr_addr_q, 0), 23'h200000);
    check("t1_wr_data", q32(wr_data_q, 0), 32'h1200_F010);
    check("t1_audio", q32(aud_q, 0), 32'h1200_F010);
`ifdef MIX_CLIP_COUNT_EN
    check("t1_clip", mix_clip_cnt, 16'd0);
`endif

    // Positive saturation on both halves.
    mem[src[0]] = 32'h7000_7000;
    mem[src[1]] = 32'h7000_7000;
    run_mix(8'b0000_0011, 16'd1, 23'h200000, cyc);
    check("t2_wr_data", q32(wr_data_q, 0), 32'h7FFF_7FFF);
    check("t2_audio", q32(aud_q, 0), 32'h7FFF_7FFF);
`ifdef MIX_CLIP_COUNT_EN
    check("t2_clip", mix_clip_cnt, 16'd1);
`endif

    // Arithmetic shift by 3: 8000 -> F000, 4000 -> 0800.
    mem[src[0]] = 32'h8000_4000;
    gain[0] = 3'd3;
    run_mix(8'b0000_0001, 16'd1, 23'h200000, cyc);
    check("t3_wr_data", q32(wr_data_q, 0), 32'hF000_0800);
`ifdef MIX_CLIP_COUNT_EN
    check("t3_clip_cleared", mix_clip_cnt, 16'd0);
`endif
    gain = '0;

    // Destination wrap across the address space, with slow SDRAM.
    sd_wait = 2;
    mem[src[0]]            = 32'h1111_2222;
    mem[src[0] + 23'd1]    = 32'h3333_4444;
    run_mix(8'b0000_0001, 16'd2, 23'h7FFFFF, cyc);
    check("t4_rd1", q32(rd_q, 1), src[0] + 23'd1);
    check("t4_wr_addr0", q32(wr_addr_q, 0), 23'h7FFFFF);
    check("t4_wr_addr1", q32(wr_addr_q, 1), 23'h000000);
    check("t4_wr_data1", q32(wr_data_q, 1), 32'h3333_4444);
    sd_wait = 0;

    // Empty mask: immediate done, no traffic.
    run_mix(8'b0000_0000, 16'd5, 23'h200000, cyc);
    check("t5_done_fast", (cyc >= 1 && cyc <= 2), 1'b1);
    check("t5_no_traffic", traffic_cnt, 0);

    // Back-pressure on the audio sink, then reset mid-transfer.
    clear_logs();
    mem[src[0]] = 32'h1234_5678;
    mix_audio_ready = 1'b0;
    mix_ch_en = 8'b0000_0001;
    mix_len = 16'd1;
    mix_start = 1'b1;
    @(negedge i_clk);
    mix_start = 1'b0;
    got_valid = 1'b0;
    for (int k = 0; k < 100 && !got_valid; k++) begin
      if (mix_audio_valid) got_valid = 1'b1;
      else @(negedge i_clk);
    end
    check("t6_valid_seen", got_valid, 1'b1);
    held   = mix_audio_data;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (!mix_audio_valid || mix_audio_data !== held) stable = 1'b0;
    end
    check("t6_stable", stable, 1'b1);
    check("t6_data", held, 32'h1234_5678);
    i_rst = 1'b0;
    #1;
    check("t6_rst_valid", mix_audio_valid, 1'b0);
    check("t6_rst_data", mix_audio_data, 32'h0);
    check("t6_rst_busy", mix_busy, 1'b0);
    check("t6_rst_wdata", mix_writedata, 32'h0);
    check("t6_rst_state", dut.state_reg, IDLE);
    check("t6_no_audio", aud_q.size(), 0);
    check("rw_never_both", rw_overlap, 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    mix_audio_ready = 1'b1;
    @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mix_engine.md
Name: mix_engine

Overview:
- Parametrised multi-track audio mixer. It sits between the playback controller, the shared SDRAM port and the audio DAC stream.
- On start it mixes a block of stereo words. For each word it reads one sample per enabled channel from SDRAM, applies a per-channel attenuation shift, and sums the results with saturation.
- Each mixed word is written back to a destination address in SDRAM and also streamed to the audio output.
- Generalises the earlier fixed five-address mixer with configurable channel count, sample width, per-channel gain and block length.

Parameters:
- NUM_CH, 8, number of source channels (2..16).
- ADDR_W, 23, SDRAM word address width.
- SAMP_W, 16, width of one signed sample; each data word is {left, right}, i.e. 2*SAMP_W bits.
- LEN_W, 16, width of the block length counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-low reset.
- mix_start  in  1  one-cycle pulse; accepted only in IDLE.
- mix_src_addr  in  NUM_CH x ADDR_W  start word address per channel; latched at start.
- mix_dst_addr  in  ADDR_W  destination start address; latched at start.
- mix_ch_en  in  NUM_CH  channel enable mask; latched at start.
- mix_gain  in  NUM_CH x 3  per-channel arithmetic right shift, 0..7; latched at start.
- mix_len  in  LEN_W  number of words to mix; latched at start.
- mix_busy  out  1  high from the cycle after start until done.
- mix_done  out  1  one-cycle pulse when the block completes.
- mix_read  out  1  SDRAM read request.
- mix_write  out  1  SDRAM write request.
- mix_addr  out  ADDR_W  SDRAM address.
- mix_writedata  out  2*SAMP_W  SDRAM write data.
- mix_readdata  in  2*SAMP_W  SDRAM read data; valid in the cycle mix_sdram_finished is high.
- mix_sdram_finished  in  1  transaction-complete strobe.
- mix_audio_valid  out  1  audio sample valid.
- mix_audio_data  out  2*SAMP_W  mixed {left, right} sample.
- mix_audio_ready  in  1  audio sink ready.

Behaviour:
- Reset (asynchronous, i_rst low): FSM goes to IDLE. All outputs are 0: busy, done, read, write, addr, writedata, audio_valid, audio_data. Any in-flight SDRAM transaction is abandoned.
- FSM states are IDLE, RD_REQ, RD_WAIT, ACC, WR_REQ, WR_WAIT, AUD, NEXT, DONE.
- IDLE: on mix_start, latch all mix_* configuration inputs.
  - If mix_ch_en is 0 or mix_len is 0, go to DONE; no SDRAM or audio traffic occurs.
  - Otherwise clear the accumulators, select the lowest enabled channel and go to RD_REQ.
  - mix_start while busy is ignored.
- RD_REQ: drive mix_read=1 and mix_addr = src_addr[ch] + word_idx, modulo 2^ADDR_W. Go to RD_WAIT.
- RD_WAIT: hold mix_read and mix_addr stable until mix_sdram_finished=1.
  - In that cycle, capture mix_readdata and drop mix_read on the next edge, then go to ACC.
  - mix_sdram_finished is ignored when no request is asserted.
- ACC: for each half, add sign_extend(sample) >>> gain[ch] into an accumulator of width SAMP_W + clog2(NUM_CH) + 1.
  - If more channels are enabled, advance to the next higher enabled channel and go to RD_REQ.
  - Otherwise saturate each half to [-2^(SAMP_W-1), 2^(SAMP_W-1)-1] and go to WR_REQ.
- WR_REQ/WR_WAIT: drive mix_write=1, mix_addr = dst + word_idx (modulo 2^ADDR_W) and mix_writedata = saturated word. Hold until finished, then go to AUD.
- AUD: drive mix_audio_valid=1 with mix_audio_data = the same word.
  - Data must stay stable while valid is high and ready is low.
  - The transfer completes in the cycle where valid and ready are both high; valid drops the next cycle.
- NEXT: increment word_idx and clear the accumulators. If word_idx equals len, go to DONE; otherwise select the lowest enabled channel and go to RD_REQ.
- DONE: assert mix_done for exactly one cycle with busy=0, then go to IDLE. A new start is accepted in the cycle after done.
- mix_read and mix_write are never asserted in the same cycle.
- Minimum cycles per word with zero-wait SDRAM and an always-ready sink: 3·E + 4, where E is the number of enabled channels.

Optional Feature:
- Macro: MIX_CLIP_COUNT_EN.
- When defined, the block adds output port mix_clip_cnt [15:0].
  - It counts words in which either half saturated and stops counting at 16'hFFFF.
  - It is cleared at reset and when a start is accepted.
- When not defined, the port is absent and no counter logic exists.

Decomposition:
- Package mix_pkg holds:
  - the state enum typedef;
  - the functions sat_sample() and acc_width (computed as SAMP_W + $clog2(NUM_CH) + 1);
  - the constant GAIN_W = 3.
- One sub-module, mix_sat_acc, holds one channel-half accumulator with shift, add, clear and saturate. It is instantiated twice, for left and right.

Test Plan:
- NUM_CH=8, mask 8'b0000_0101, gain 0, len 1, ch0 word {16'h1000, 16'hF000}, ch2 word {16'h0200, 16'h0010}:
  - exactly 2 reads at src0 and src2;
  - then 1 write to dst with data {16'h1200, 16'hF010};
  - audio data equals the write data, then a done pulse.
- ch0 and ch1 both 16'h7000 on both halves, gain 0, len 1 → output {16'h7FFF, 16'h7FFF}; with MIX_CLIP_COUNT_EN, mix_clip_cnt=1.
- ch0 = 16'h8000, gain[0]=3, single channel → half value 16'hF000, showing arithmetic shift.
- dst_addr = 23'h7FFFFF, len 2 → writes go to 23'h7FFFFF then 23'h000000.
- mask 0 and len 5 → done pulse two cycles after start, with no read, write or audio_valid asserted.
- mix_audio_ready held low for 10 cycles:
  - mix_audio_valid and mix_audio_data stay stable throughout;
  - i_rst is asserted low mid-transaction: all outputs are 0 immediately and the FSM is in IDLE.
